// File: rtl/axi4_lite_slave_regfile.sv
// AXI4-Lite slave register file: NUM_REGS x 32-bit registers with byte strobes,
// independent one-entry AW/W buffers, registered readies and a flat register view.
module axi4_lite_slave_regfile #(
    parameter int unsigned NUM_REGS    = 16,
    parameter logic [31:0] RESET_VALUE = 32'h0000_0000
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic [31:0]              awaddr_in,
    input  logic [2:0]               awprot_in,
    input  logic                     awvalid_in,
    output logic                     awready_out,
    input  logic [31:0]              wdata_in,
    input  logic [3:0]               wstrb_in,
    input  logic                     wvalid_in,
    output logic                     wready_out,
    output logic [1:0]               bresp_out,
    output logic                     bvalid_out,
    input  logic                     bready_in,
    input  logic [31:0]              araddr_in,
    input  logic [2:0]               arprot_in,
    input  logic                     arvalid_in,
    output logic                     arready_out,
    output logic [31:0]              rdata_out,
    output logic [1:0]               rresp_out,
    output logic                     rvalid_out,
    input  logic                     rready_in,
    output logic [NUM_REGS*32-1:0]   regs_out
);

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlverr = 2'b10;

    logic                     aw_full_q, aw_full_d;
    logic [29:0]              aw_idx_q, aw_idx_d;
    logic                     awready_q, awready_d;
    logic                     w_full_q, w_full_d;
    logic [31:0]              wdata_q, wdata_d;
    logic [3:0]               wstrb_q, wstrb_d;
    logic                     wready_q, wready_d;
    logic                     bvalid_q, bvalid_d;
    logic [1:0]               bresp_q, bresp_d;
    logic                     rvalid_q, rvalid_d;
    logic [31:0]              rdata_q, rdata_d;
    logic [1:0]               rresp_q, rresp_d;
    logic                     arready_q, arready_d;
    logic [NUM_REGS-1:0][31:0] regs_q, regs_d;

    logic        aw_hs, w_hs, ar_hs, commit;
    logic        aw_in_range, ar_in_range;
    logic [29:0] ar_idx;
    logic [31:0] rd_word;

    // Protection bits and byte-offset address bits carry no meaning here.
    logic unused_inputs;
    assign unused_inputs = ^{awprot_in, arprot_in, awaddr_in[1:0], araddr_in[1:0]};

    assign aw_hs       = awvalid_in & awready_q;
    assign w_hs        = wvalid_in & wready_q;
    assign ar_hs       = arvalid_in & arready_q;
    assign commit      = aw_full_q & w_full_q & ~bvalid_q;
    assign ar_idx      = araddr_in[31:2];
    assign aw_in_range = aw_idx_q < 30'(NUM_REGS);
    assign ar_in_range = ar_idx < 30'(NUM_REGS);

    // Write path: holding buffers, commit and B channel.
    always_comb begin
        aw_full_d = aw_full_q;
        aw_idx_d  = aw_idx_q;
        w_full_d  = w_full_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        regs_d    = regs_q;

        if (aw_hs) begin
            aw_full_d = 1'b1;
            aw_idx_d  = awaddr_in[31:2];
        end
        if (w_hs) begin
            w_full_d = 1'b1;
            wdata_d  = wdata_in;
            wstrb_d  = wstrb_in;
        end

        if (commit) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = aw_in_range ? RespOkay : RespSlverr;
            for (int k = 0; k < NUM_REGS; k++) begin
                if (aw_in_range && aw_idx_q == 30'(k)) begin
                    for (int b = 0; b < 4; b++) begin
                        if (wstrb_q[b]) begin
                            regs_d[k][8*b +: 8] = wdata_q[8*b +: 8];
                        end
                    end
                end
            end
        end else if (bvalid_q && bready_in) begin
            bvalid_d = 1'b0;
        end

        awready_d = ~aw_full_d;
        wready_d  = ~w_full_d;
    end

    // Read path: reads sample pre-commit register contents.
    always_comb begin
        rd_word = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (ar_idx == 30'(k)) begin
                rd_word = regs_q[k];
            end
        end

        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = ar_in_range ? rd_word : 32'h0;
            rresp_d  = ar_in_range ? RespOkay : RespSlverr;
        end else if (rvalid_q && rready_in) begin
            rvalid_d = 1'b0;
        end
        arready_d = ~rvalid_d;
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            aw_full_q <= 1'b0;
            aw_idx_q  <= '0;
            awready_q <= 1'b0;
            w_full_q  <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RespOkay;
        end else begin
            aw_full_q <= aw_full_d;
            aw_idx_q  <= aw_idx_d;
            awready_q <= awready_d;
            w_full_q  <= w_full_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RespOkay;
            arready_q <= 1'b0;
        end else begin
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            arready_q <= arready_d;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            regs_q <= {NUM_REGS{RESET_VALUE}};
        end else begin
            regs_q <= regs_d;
        end
    end

    assign awready_out = awready_q;
    assign wready_out  = wready_q;
    assign bvalid_out  = bvalid_q;
    assign bresp_out   = bresp_q;
    assign arready_out = arready_q;
    assign rvalid_out  = rvalid_q;
    assign rdata_out   = rdata_q;
    assign rresp_out   = rresp_q;
    assign regs_out    = regs_q;

endmodule

// File: tb/tb_axi4_lite_slave_regfile.sv
// Directed bench for axi4_lite_slave_regfile: table of write/read vectors plus
// hand-written sequences for ordering, back-pressure, read/write collision and reset.
module tb_axi4_lite_slave_regfile;

    localparam int NREGS = 16;

    logic              aclk = 1'b0;
    logic              areset;
    logic [31:0]       awaddr_in;
    logic [2:0]        awprot_in;
    logic              awvalid_in;
    logic              awready_out;
    logic [31:0]       wdata_in;
    logic [3:0]        wstrb_in;
    logic              wvalid_in;
    logic              wready_out;
    logic [1:0]        bresp_out;
    logic              bvalid_out;
    logic              bready_in;
    logic [31:0]       araddr_in;
    logic [2:0]        arprot_in;
    logic              arvalid_in;
    logic              arready_out;
    logic [31:0]       rdata_out;
    logic [1:0]        rresp_out;
    logic              rvalid_out;
    logic              rready_in;
    logic [NREGS*32-1:0] regs_out;

    axi4_lite_slave_regfile #(
        .NUM_REGS    (NREGS),
        .RESET_VALUE (32'h0000_0000)
    ) dut (
        .aclk        (aclk),
        .areset      (areset),
        .awaddr_in   (awaddr_in),
        .awprot_in   (awprot_in),
        .awvalid_in  (awvalid_in),
        .awready_out (awready_out),
        .wdata_in    (wdata_in),
        .wstrb_in    (wstrb_in),
        .wvalid_in   (wvalid_in),
        .wready_out  (wready_out),
        .bresp_out   (bresp_out),
        .bvalid_out  (bvalid_out),
        .bready_in   (bready_in),
        .araddr_in   (araddr_in),
        .arprot_in   (arprot_in),
        .arvalid_in  (arvalid_in),
        .arready_out (arready_out),
        .rdata_out   (rdata_out),
        .rresp_out   (rresp_out),
        .rvalid_out  (rvalid_out),
        .rready_in   (rready_in),
        .regs_out    (regs_out)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  bresp;
        logic [31:0] rdata;
        logic [1:0]  rresp;
    } vec_t;

    vec_t vecs[7];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for handshake", name);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output logic [1:0] resp);
        int n;
        n = 0;
        resp = 2'bxx;
        while (!(awready_out && wready_out) && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) begin
            timeout("write_ready");
            return;
        end
        awaddr_in  = addr;
        wdata_in   = data;
        wstrb_in   = strb;
        awvalid_in = 1'b1;
        wvalid_in  = 1'b1;
        tick();
        awvalid_in = 1'b0;
        wvalid_in  = 1'b0;
        n = 0;
        while (!bvalid_out && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) begin
            timeout("write_bvalid");
            return;
        end
        resp      = bresp_out;
        bready_in = 1'b1;
        tick();
        bready_in = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] addr, output logic [31:0] data,
                           output logic [1:0] resp);
        int n;
        n = 0;
        data = 'x;
        resp = 2'bxx;
        while (!arready_out && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) begin
            timeout("read_ready");
            return;
        end
        araddr_in  = addr;
        arvalid_in = 1'b1;
        tick();
        arvalid_in = 1'b0;
        n = 0;
        while (!rvalid_out && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) begin
            timeout("read_rvalid");
            return;
        end
        data      = rdata_out;
        resp      = rresp_out;
        rready_in = 1'b1;
        tick();
        rready_in = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]          resp;
        logic [1:0]          rresp;
        logic [31:0]         rdata;
        logic [NREGS*32-1:0] snap;

        vecs[0] = '{32'h0000_0000, 32'h1234_5678, 4'hF, 2'b00, 32'h1234_5678, 2'b00};
        vecs[1] = '{32'h0000_0000, 32'hAABB_CCDD, 4'h3, 2'b00, 32'h1234_CCDD, 2'b00};
        vecs[2] = '{32'h0000_003C, 32'hCAFE_F00D, 4'h8, 2'b00, 32'hCA00_0000, 2'b00};
        vecs[3] = '{32'h0000_003F, 32'h1111_1111, 4'h0, 2'b00, 32'hCA00_0000, 2'b00};
        vecs[4] = '{32'h0000_0040, 32'hFFFF_FFFF, 4'hF, 2'b10, 32'h0000_0000, 2'b10};
        vecs[5] = '{32'h8000_0000, 32'h7777_7777, 4'hF, 2'b10, 32'h0000_0000, 2'b10};
        vecs[6] = '{32'h0000_0016, 32'h0F0F_0F0F, 4'h6, 2'b00, 32'h000F_0F00, 2'b00};

        areset     = 1'b1;
        awaddr_in  = '0;
        awprot_in  = 3'b010;
        awvalid_in = 1'b0;
        wdata_in   = '0;
        wstrb_in   = '0;
        wvalid_in  = 1'b0;
        bready_in  = 1'b0;
        araddr_in  = '0;
        arprot_in  = 3'b101;
        arvalid_in = 1'b0;
        rready_in  = 1'b0;

        // Reset state
        repeat (2) tick();
        check("rst_awready", awready_out, 0);
        check("rst_wready", wready_out, 0);
        check("rst_arready", arready_out, 0);
        check("rst_bvalid", bvalid_out, 0);
        check("rst_rvalid", rvalid_out, 0);
        check("rst_bresp", bresp_out, 0);
        check("rst_rresp", rresp_out, 0);
        check("rst_rdata", rdata_out, 0);
        check("rst_regs", regs_out[63:0], 0);
        areset = 1'b0;
        #1;
        check("rel_awready_before_edge", awready_out, 0);
        tick();
        check("rel_awready", awready_out, 1);
        check("rel_wready", wready_out, 1);
        check("rel_arready", arready_out, 1);

        // Sequence 1: AW and W together, exact latency
        awaddr_in  = 32'h04;
        wdata_in   = 32'hDEAD_BEEF;
        wstrb_in   = 4'hF;
        awvalid_in = 1'b1;
        wvalid_in  = 1'b1;
        tick();
        awvalid_in = 1'b0;
        wvalid_in  = 1'b0;
        check("s1_bvalid_early", bvalid_out, 0);
        check("s1_awready_full", awready_out, 0);
        check("s1_wready_full", wready_out, 0);
        tick();
        check("s1_bvalid", bvalid_out, 1);
        check("s1_bresp", bresp_out, 2'b00);
        check("s1_reg1", regs_out[63:32], 32'hDEAD_BEEF);
        bready_in = 1'b1;
        tick();
        bready_in = 1'b0;
        check("s1_bvalid_clr", bvalid_out, 0);

        // Sequence 2: W first, AW three cycles later
        wdata_in  = 32'h1122_3344;
        wstrb_in  = 4'b0101;
        wvalid_in = 1'b1;
        tick();
        wvalid_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("s2_awready_wait", awready_out, 1);
            check("s2_wready_wait", wready_out, 0);
            check("s2_no_bvalid", bvalid_out, 0);
            tick();
        end
        awaddr_in  = 32'h08;
        awvalid_in = 1'b1;
        tick();
        awvalid_in = 1'b0;
        tick();
        check("s2_bvalid", bvalid_out, 1);
        check("s2_bresp", bresp_out, 2'b00);
        check("s2_reg2", regs_out[95:64], 32'h0022_0044);
        bready_in = 1'b1;
        tick();
        bready_in = 1'b0;

        // Sequence 3: out-of-range write and read
        snap = regs_out;
        do_write(32'h40, 32'hFFFF_FFFF, 4'hF, resp);
        check("s3_bresp", resp, 2'b10);
        check("s3_regs_unchanged", regs_out == snap, 1);
        do_read(32'h40, rdata, rresp);
        check("s3_rresp", rresp, 2'b10);
        check("s3_rdata", rdata, 0);

        // Sequence 4: B back-pressure with a second write queued
        awaddr_in  = 32'h0C;
        wdata_in   = 32'h0101_0101;
        wstrb_in   = 4'hF;
        awvalid_in = 1'b1;
        wvalid_in  = 1'b1;
        tick();
        tick();
        check("s4_first_bvalid", bvalid_out, 1);
        awaddr_in = 32'h10;
        wdata_in  = 32'h0202_0202;
        tick();
        awvalid_in = 1'b0;
        wvalid_in  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("s4_bvalid_held", bvalid_out, 1);
            check("s4_bresp_held", bresp_out, 2'b00);
            check("s4_reg4_pending", regs_out[159:128], 0);
            tick();
        end
        check("s4_reg3", regs_out[127:96], 32'h0101_0101);
        bready_in = 1'b1;
        tick();
        bready_in = 1'b0;
        check("s4_bvalid_after_hs", bvalid_out, 0);
        check("s4_reg4_not_yet", regs_out[159:128], 0);
        tick();
        check("s4_second_bvalid", bvalid_out, 1);
        check("s4_reg4", regs_out[159:128], 32'h0202_0202);
        bready_in = 1'b1;
        tick();
        bready_in = 1'b0;

        // Sequence 5: read and commit on the same edge, R back-pressure
        awaddr_in  = 32'h04;
        wdata_in   = 32'h5566_7788;
        wstrb_in   = 4'hF;
        awvalid_in = 1'b1;
        wvalid_in  = 1'b1;
        tick();
        awvalid_in = 1'b0;
        wvalid_in  = 1'b0;
        araddr_in  = 32'h04;
        arvalid_in = 1'b1;
        tick();
        arvalid_in = 1'b0;
        check("s5_commit_bvalid", bvalid_out, 1);
        check("s5_reg1_new", regs_out[63:32], 32'h5566_7788);
        bready_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("s5_rvalid_held", rvalid_out, 1);
            check("s5_rdata_old", rdata_out, 32'hDEAD_BEEF);
            check("s5_rresp", rresp_out, 2'b00);
            check("s5_arready_low", arready_out, 0);
            tick();
            bready_in = 1'b0;
        end
        rready_in = 1'b1;
        tick();
        rready_in = 1'b0;
        check("s5_rvalid_clr", rvalid_out, 0);
        check("s5_arready_back", arready_out, 1);
        do_read(32'h04, rdata, rresp);
        check("s5_rdata_new", rdata, 32'h5566_7788);

        // Sequence 6: reset with a buffered AW and pending R
        awaddr_in  = 32'h00;
        awvalid_in = 1'b1;
        araddr_in  = 32'h08;
        arvalid_in = 1'b1;
        tick();
        awvalid_in = 1'b0;
        arvalid_in = 1'b0;
        check("s6_aw_buffered", awready_out, 0);
        check("s6_rvalid_pending", rvalid_out, 1);
        areset = 1'b1;
        #1;
        check("s6_awready", awready_out, 0);
        check("s6_wready", wready_out, 0);
        check("s6_arready", arready_out, 0);
        check("s6_rvalid", rvalid_out, 0);
        check("s6_bvalid", bvalid_out, 0);
        check("s6_rdata", rdata_out, 0);
        check("s6_regs_cleared", regs_out == '0, 1);
        tick();
        areset = 1'b0;
        tick();
        check("s6_awready_rel", awready_out, 1);
        check("s6_arready_rel", arready_out, 1);
        for (int i = 0; i < 3; i++) begin
            check("s6_no_b", bvalid_out, 0);
            check("s6_no_r", rvalid_out, 0);
            tick();
        end

        // Table-driven write-then-read vectors from cleared registers
        for (int i = 0; i < 7; i++) begin
            snap = regs_out;
            do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, resp);
            check($sformatf("vec%0d_bresp", i), resp, vecs[i].bresp);
            do_read(vecs[i].addr, rdata, rresp);
            check($sformatf("vec%0d_rresp", i), rresp, vecs[i].rresp);
            check($sformatf("vec%0d_rdata", i), rdata, vecs[i].rdata);
            if (vecs[i].rresp == 2'b00) begin
                check($sformatf("vec%0d_regs_out", i),
                      regs_out[32*vecs[i].addr[5:2] +: 32], vecs[i].rdata);
            end else begin
                check($sformatf("vec%0d_regs_unchanged", i), regs_out == snap, 1);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi4_lite_slave_regfile.md
Name: axi4_lite_slave_regfile

Overview:
- AXI4-Lite slave register file; the downstream consumer of the team's AXI4-Lite master adaptor.
- Accepts write-address, write-data and read-address transactions and stores data in NUM_REGS 32-bit registers with byte strobes.
- Returns write and read responses.
- Exposes all register contents as a flat bus for local control logic.

Parameters:
NUM_REGS, 16, number of 32-bit registers; word index = addr[31:2]; valid indices 0..NUM_REGS-1
RESET_VALUE, 32'h0000_0000, reset contents of every register

Ports:
aclk  input  1  clock, all state on rising edge
areset  input  1  asynchronous, active-high reset
awaddr_in  input  32  write address
awprot_in  input  3  write protection, accepted and ignored
awvalid_in  input  1  write address valid
awready_out  output  1  write address ready
wdata_in  input  32  write data
wstrb_in  input  4  byte strobes, bit i enables wdata_in[8i+7:8i]
wvalid_in  input  1  write data valid
wready_out  output  1  write data ready
bresp_out  output  2  write response: 2'b00 OKAY, 2'b10 SLVERR
bvalid_out  output  1  write response valid
bready_in  input  1  write response ready
araddr_in  input  32  read address
arprot_in  input  3  read protection, accepted and ignored
arvalid_in  input  1  read address valid
arready_out  output  1  read address ready
rdata_out  output  32  read data
rresp_out  output  2  read response: 2'b00 OKAY, 2'b10 SLVERR
rvalid_out  output  1  read data valid
rready_in  input  1  read data ready
regs_out  output  NUM_REGS*32  register contents; register k occupies bits [32k+31:32k]

Behaviour:

Reset:
- areset asserted at any time clears aw_full, w_full, bvalid_out, rvalid_out.
- All registers are set to RESET_VALUE.
- awready_out, wready_out, arready_out are 0 during reset and the cycle it is applied.
- bresp_out, rresp_out, rdata_out are 0.
- In-flight transactions are dropped without a response.

AW and W channels (independent one-entry holding buffers):
- awready_out = !aw_full. wready_out = !w_full.
- Both readies are registered and return to 1 on the first edge after areset deasserts.
- An AW handshake (awvalid_in & awready_out) latches awaddr_in and sets aw_full.
- A W handshake latches wdata_in and wstrb_in and sets w_full.
- AW and W may arrive in either order or in the same cycle. Each can be held indefinitely while waiting for the other.

Write commit:
- A commit happens on an edge where aw_full & w_full & !bvalid_out.
- If index < NUM_REGS: the strobed bytes of that register are updated and bresp_out = OKAY.
- Otherwise: no register changes and bresp_out = SLVERR.
- The same edge clears aw_full and w_full and sets bvalid_out.
- Latency: AW and W accepted at edge T → commit and bvalid_out=1 after edge T+1.
- wstrb = 4'b0000 is a legal no-op write with response OKAY.

Write response:
- bvalid_out and bresp_out are held stable until bready_in is seen high on an edge; bvalid_out then clears.
- While bvalid_out=1, new AW/W may still fill the empty buffers, but their commit waits until after bvalid_out clears.
- The earliest next commit is the edge after the B handshake.

Read path:
- arready_out = !rvalid_out, registered, 0 in reset.
- An AR handshake at edge T sets rvalid_out after edge T.
- rdata_out = register[index] as sampled before any write committing on that same edge (old value), rresp_out = OKAY.
- Out-of-range index: rdata_out = 0, rresp_out = SLVERR.
- rdata_out, rresp_out and rvalid_out are held stable until rready_in is high on an edge; rvalid_out then clears and arready_out returns to 1 after that edge.
- Maximum read throughput: one read per two cycles.

Channel independence and address handling:
- Read and write paths are independent and may be active simultaneously.
- Address bits [1:0] are ignored. Indexing uses the full addr[31:2], so aliasing never occurs.
- regs_out reflects register state directly (no extra latency).

Test Plan:
- Reset then AW=0x04 and W=0xDEADBEEF/strb 4'hF in the same cycle → bvalid_out=1 two edges later with bresp 00; regs_out[63:32]=0xDEADBEEF.
- W first (0x11223344, strb 4'b0101), AW 0x08 three cycles later → reg2 = 0x00220044 (from 0); awready_out stays 1 and wready_out stays 0 in between.
- AW 0x40 (NUM_REGS=16) with W 0xFFFFFFFF → bresp 10; no regs_out change. AR 0x40 → rresp 10, rdata_out 0.
- Hold bready_in=0 for 5 cycles after a write while issuing a second AW/W → bvalid_out and bresp stable; second commit occurs only on the edge after the first B handshake.
- AR 0x04 and a write to 0x04 committing on the same edge → rdata_out is the old value; a following read returns the new value. rready_in low 3 cycles → rvalid_out and rdata_out held, arready_out=0.
- Assert areset with aw_full=1 and rvalid_out=1 → all valids and readies 0 immediately, regs = RESET_VALUE, no B/R response after release.
